parking_gate_arbiter: RTL and testbench
=======================================

# parking_gate_arbiter

Sequences the single shared barrier gate of the parking lot lane between entering and exiting cars. It grants the gate to one direction at a time and drives the gate motor through raise, pass and lower phases. It refuses entry when the lot is at capacity. It sits beside `car_counter`: it reads the live occupancy `count` and consumes the `enter`/`exit` completion pulses from `carDetect`.

## Interface
- `CAPACITY`, default 25: maximum occupancy. Legal range 1..31, because `count` is 5 bits.
- `MOTOR_CYCLES`, default 4: number of cycles the gate motor runs to fully raise or fully lower. Must be ≥1.
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles in PASS without a completion pulse. Must be ≥1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enter_req` in 1: a car is waiting at the outer side, level signal, already synchronized.
- `exit_req` in 1: a car is waiting at the inner side, level signal, already synchronized.
- `count` in 5: current occupancy from `car_counter`.
- `enter_done` in 1: 1-cycle pulse from `carDetect`; a car has completed entry.
- `exit_done` in 1: 1-cycle pulse from `carDetect`; a car has completed exit.
- `grant_in` out 1: the gate is allocated to an entering car.
- `grant_out` out 1: the gate is allocated to an exiting car.
- `motor_up` out 1: raise command.
- `motor_down` out 1: lower command.
- `gate_open` out 1: the gate is fully raised.
- `busy` out 1: the FSM is in any state other than IDLE.
- `full` out 1: registered flag, `count >= CAPACITY`.
- `timeout` out 1: 1-cycle pulse when PASS is abandoned.

## Operation
- All outputs are registered. On `reset` low, every output is 0, the FSM is in IDLE, both counters are 0, and `last_dir` = IN.
- Eligibility, evaluated only in IDLE:
  - `elig_in` = `enter_req` && (`count` < `CAPACITY`).
  - `elig_out` = `exit_req` && (`count` != 0).
- Arbitration in IDLE:
  - Only one direction eligible: grant that direction.
  - Both eligible: grant the direction opposite to `last_dir` (round-robin). After reset, the first tie therefore goes to OUT.
  - Neither eligible: stay in IDLE.
  - On grant, latch `dir` and set `last_dir` = `dir`.
- FSM states and outputs:
  - IDLE: all status outputs low.
  - RAISE: `motor_up` = 1. Lasts exactly `MOTOR_CYCLES` cycles, then goes to PASS.
  - PASS: `gate_open` = 1. The timeout counter increments each cycle.
    - `dir`-matching done pulse (`enter_done` for IN, `exit_done` for OUT) → LOWER.
    - Counter reaches `TIMEOUT_CYCLES` with no matching done → pulse `timeout`, go to LOWER.
  - LOWER: `motor_down` = 1. Lasts exactly `MOTOR_CYCLES` cycles, then goes to IDLE.
- `grant_in` / `grant_out` stay high from entry into RAISE through the last LOWER cycle.
- `busy` is high in RAISE, PASS and LOWER.
- Boundary rules:
  - Requests are sampled only in IDLE. Deasserting a request during RAISE does not abort the sequence.
  - A non-matching done pulse in PASS, or any done pulse outside PASS, is ignored. No state change occurs.
  - Matching done in the same cycle that the timeout would fire: done wins and no `timeout` pulse is issued.
  - `count` changing during a sequence has no effect until the next IDLE evaluation.
  - `full` updates every cycle regardless of state.
  - `reset` asserted mid-sequence: immediate return to IDLE with all outputs 0. The gate is not lowered by this block.
- The motor and timeout counter is sized as `$clog2(max(MOTOR_CYCLES, TIMEOUT_CYCLES)+1)` bits. It is cleared on every state entry.

## Timing
- If an eligible request is sampled in IDLE at edge t, then at edge t+1 the FSM is in RAISE and the grant and `motor_up` go high.
- `gate_open` first rises at edge t+1+`MOTOR_CYCLES`.
- For a done pulse sampled at edge d in PASS: at edge d+1 `gate_open` = 0 and `motor_down` = 1.
- IDLE is re-entered at edge d+1+`MOTOR_CYCLES`, with grant, `busy` and `motor_down` low.
- IDLE is occupied for at least 1 cycle between sequences. The next grant is issued no earlier than 1 cycle after returning to IDLE.
- Timeout case: `timeout` is high for the single cycle coinciding with the first LOWER cycle. PASS occupancy is exactly `TIMEOUT_CYCLES` cycles.
- `full` lags `count` by 1 cycle.

## Test plan
- Reset, then hold `enter_req`=1 with `count`=3 (defaults): `grant_in` and `motor_up` for 4 cycles, then `gate_open` until `enter_done`, then `motor_down` for 4 cycles, then IDLE with all outputs 0.
- `enter_req` and `exit_req` both high at `count`=5 after reset: grant order is OUT, IN, OUT, with `last_dir` alternating. Each sequence is separated by ≥1 IDLE cycle.
- `count`=25 with `enter_req`=1: `full`=1 and no grant ever issued. Raise `exit_req`: `grant_out` issued. With `count`=0, `exit_req` alone is never granted.
- Grant IN, then send no done pulse: PASS lasts 64 cycles, `timeout` pulses once, then LOWER and IDLE. An `exit_done` injected during that PASS is ignored.
- `enter_done` on the 64th PASS cycle: LOWER is entered and `timeout` stays 0.
- Drop `reset` low during PASS: all outputs 0 immediately. Release `reset` with `enter_req`=1: a normal sequence restarts from RAISE.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter
// Shares the lane's single barrier gate between entering and exiting cars.
// One direction is granted at a time (round-robin on ties), and the gate motor
// is sequenced through RAISE -> PASS -> LOWER. Entry is refused at capacity,
// and exit is refused when the lot is empty. Every output is a flop driven from
// the next-state decode, so no output glitches.
module parking_gate_arbiter #(
  parameter int CAPACITY       = 25,
  parameter int MOTOR_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [4:0] count,
  input  logic       enter_done,
  input  logic       exit_done,
  output logic       grant_in,
  output logic       grant_out,
  output logic       motor_up,
  output logic       motor_down,
  output logic       gate_open,
  output logic       busy,
  output logic       full,
  output logic       timeout
);

  localparam int MAX_CYC = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // The terminal counts are the last cycle spent in a phase. The counter starts
  // at 0 on phase entry, so a phase of N cycles ends when the counter holds N-1.
  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PASS_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       CAP        = 5'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAISE,
    S_PASS,
    S_LOWER
  } state_t;

  typedef enum logic {
    DIR_IN,
    DIR_OUT
  } dir_t;

  state_t           state, state_nxt;
  dir_t             dir, dir_nxt;
  dir_t             last_dir, last_dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic             elig_in;
  logic             elig_out;
  logic             done_match;

  // Next-state, arbitration and phase counter.
  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    last_dir_nxt = last_dir;
    cnt_nxt      = '0;
    timeout_nxt  = 1'b0;

    elig_in    = enter_req && (count < CAP);
    elig_out   = exit_req && (count != 5'd0);
    done_match = (dir == DIR_IN) ? enter_done : exit_done;

    case (state)
      S_IDLE: begin
        // Requests and occupancy only matter here. A tie goes to the
        // direction that did not win last time.
        if (elig_in || elig_out) begin
          state_nxt = S_RAISE;
          if (elig_in && elig_out) begin
            dir_nxt = (last_dir == DIR_IN) ? DIR_OUT : DIR_IN;
          end else if (elig_in) begin
            dir_nxt = DIR_IN;
          end else begin
            dir_nxt = DIR_OUT;
          end
          last_dir_nxt = dir_nxt;
        end
      end

      S_RAISE: begin
        if (cnt == MOTOR_LAST) begin
          state_nxt = S_PASS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_PASS: begin
        // A matching done pulse takes priority over a timeout in the same
        // cycle. Done pulses for the other direction are ignored.
        if (done_match) begin
          state_nxt = S_LOWER;
        end else if (cnt == PASS_LAST) begin
          state_nxt   = S_LOWER;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_LOWER: begin
        if (cnt == MOTOR_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, direction and counter registers. Reset abandons any sequence in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      dir      <= DIR_IN;
      last_dir <= DIR_IN;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      last_dir <= last_dir_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Registered outputs decoded from the next state, so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_in   <= 1'b0;
      grant_out  <= 1'b0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      gate_open  <= 1'b0;
      busy       <= 1'b0;
      full       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      grant_in   <= (state_nxt != S_IDLE) && (dir_nxt == DIR_IN);
      grant_out  <= (state_nxt != S_IDLE) && (dir_nxt == DIR_OUT);
      motor_up   <= (state_nxt == S_RAISE);
      motor_down <= (state_nxt == S_LOWER);
      gate_open  <= (state_nxt == S_PASS);
      busy       <= (state_nxt != S_IDLE);
      full       <= (count >= CAP);
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with default parameters.
// Outputs are packed as {grant_in, grant_out, motor_up, motor_down,
// gate_open, busy, full, timeout}. Each output is sampled 1 time unit after
// the rising edge, and inputs are changed at that same point.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_req, exit_req;
  logic [4:0] count;
  logic       enter_done, exit_done;
  logic       grant_in, grant_out, motor_up, motor_down;
  logic       gate_open, busy, full, timeout;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [7:0] IDLE_O    = 8'h00;
  localparam logic [7:0] FULL_O    = 8'h02;
  localparam logic [7:0] RAISE_IN  = 8'hA4;
  localparam logic [7:0] PASS_IN   = 8'h8C;
  localparam logic [7:0] LOWER_IN  = 8'h94;
  localparam logic [7:0] RAISE_OUT = 8'h64;
  localparam logic [7:0] PASS_OUT  = 8'h4C;
  localparam logic [7:0] LOWER_OUT = 8'h54;
  localparam logic [7:0] TO_BIT    = 8'h01;

  wire [7:0] obs = {grant_in, grant_out, motor_up, motor_down,
                    gate_open, busy, full, timeout};

  parking_gate_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .enter_req (enter_req),
    .exit_req  (exit_req),
    .count     (count),
    .enter_done(enter_done),
    .exit_done (exit_done),
    .grant_in  (grant_in),
    .grant_out (grant_out),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .gate_open (gate_open),
    .busy      (busy),
    .full      (full),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enter_req = 0; exit_req = 0; count = 5'd0;
    enter_done = 0; exit_done = 0;
    #1;
    vectors++;
    if (obs !== IDLE_O) begin
      miscompares++;
      $display("FAIL reset_hold got %b want %b", obs, IDLE_O);
    end
    step();
    reset = 1'b1;
    step();
    vectors++;
    if (obs !== IDLE_O) begin
      miscompares++;
      $display("FAIL reset_release got %b want %b", obs, IDLE_O);
    end
  endtask

  task automatic test_enter_seq();
    logic [7:0] exp;
    count = 5'd3; enter_req = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      // Drop the request and send a stray done pulse during RAISE. Neither changes the sequence.
      if (i == 0) begin enter_req = 0; enter_done = 1; end
      if (i == 1) enter_done = 0;
      if (i == 6) enter_done = 1;
      if (i == 7) enter_done = 0;
      if (i < 4)       exp = RAISE_IN;
      else if (i < 7)  exp = PASS_IN;
      else if (i < 11) exp = LOWER_IN;
      else             exp = IDLE_O;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL enter_seq cycle %0d got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] r, p, l, exp;
    logic       is_out;
    pulse_reset();
    count = 5'd5; enter_req = 1; exit_req = 1;
    for (int s = 0; s < 3; s++) begin
      is_out = (s != 1);
      r = is_out ? RAISE_OUT : RAISE_IN;
      p = is_out ? PASS_OUT : PASS_IN;
      l = is_out ? LOWER_OUT : LOWER_IN;
      for (int i = 0; i < 10; i++) begin
        step();
        if (i == 4) begin
          if (is_out) exit_done = 1; else enter_done = 1;
        end
        if (i == 5) begin enter_done = 0; exit_done = 0; end
        if (i == 9 && s == 2) begin enter_req = 0; exit_req = 0; end
        if (i < 4)      exp = r;
        else if (i < 5) exp = p;
        else if (i < 9) exp = l;
        else            exp = IDLE_O;
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL round_robin seq %0d cycle %0d got %b want %b", s, i, obs, exp);
        end
      end
    end
    step();
    vectors++;
    if (obs !== IDLE_O) begin
      miscompares++;
      $display("FAIL round_robin_end got %b want %b", obs, IDLE_O);
    end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    count = 5'd25; enter_req = 1; exit_req = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (obs !== FULL_O) begin
        miscompares++;
        $display("FAIL full_refuse cycle %0d got %b want %b", i, obs, FULL_O);
      end
    end
    exit_req = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) exit_req = 0;
      // The lot drops below capacity mid-sequence. full follows, but the sequence does not change.
      if (i == 4) begin count = 5'd24; enter_req = 0; exit_done = 1; end
      if (i == 5) exit_done = 0;
      if (i < 4)       exp = RAISE_OUT | FULL_O;
      else if (i < 5)  exp = PASS_OUT | FULL_O;
      else if (i < 9)  exp = LOWER_OUT;
      else             exp = IDLE_O;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL full_exit cycle %0d got %b want %b", i, obs, exp);
      end
    end
    count = 5'd0; exit_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (obs !== IDLE_O) begin
        miscompares++;
        $display("FAIL empty_exit cycle %0d got %b want %b", i, obs, IDLE_O);
      end
    end
    exit_req = 0;
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    count = 5'd3; enter_req = 1;
    for (int i = 0; i < 73; i++) begin
      step();
      if (i == 0) enter_req = 0;
      if (i == 14) exit_done = 1;
      if (i == 15) exit_done = 0;
      if (i < 4)        exp = RAISE_IN;
      else if (i < 68)  exp = PASS_IN;
      else if (i == 68) exp = LOWER_IN | TO_BIT;
      else if (i < 72)  exp = LOWER_IN;
      else              exp = IDLE_O;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL timeout cycle %0d got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_done_at_timeout();
    logic [7:0] exp;
    count = 5'd3; enter_req = 1;
    for (int i = 0; i < 73; i++) begin
      step();
      if (i == 0) enter_req = 0;
      if (i == 67) enter_done = 1;
      if (i == 68) enter_done = 0;
      if (i < 4)       exp = RAISE_IN;
      else if (i < 68) exp = PASS_IN;
      else if (i < 72) exp = LOWER_IN;
      else             exp = IDLE_O;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL done_at_timeout cycle %0d got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    count = 5'd3; enter_req = 1;
    for (int i = 0; i < 6; i++) step();
    vectors++;
    if (obs !== PASS_IN) begin
      miscompares++;
      $display("FAIL reset_mid_pre got %b want %b", obs, PASS_IN);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (obs !== IDLE_O) begin
      miscompares++;
      $display("FAIL reset_mid_async got %b want %b", obs, IDLE_O);
    end
    #1;
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 0) enter_req = 0;
      if (i == 5) enter_done = 1;
      if (i == 6) enter_done = 0;
      if (i < 4)       exp = RAISE_IN;
      else if (i < 6)  exp = PASS_IN;
      else if (i < 10) exp = LOWER_IN;
      else             exp = IDLE_O;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_restart cycle %0d got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enter_seq();
    test_round_robin();
    test_full();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
